// File: rtl/serdes_pkg.sv
// serdes_pkg: BER checker state type, PRBS tap lookup and default parameters
package serdes_pkg;
  typedef enum logic [2:0] {IDLE, SEED, VERIFY, LOCKED, DONE} ber_state_e;
  localparam int DEF_PRBS_ORDER = 7;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_LOCK_CNT = 16;
  localparam int DEF_LOSS_WIN = 64;
  localparam int DEF_LOSS_THRESH = 8;
  // {hi, lo} 1-based feedback taps for a supported order; 0 flags an unsupported order
  function automatic logic [15:0] prbs_taps(input int order);
    return order == 7 ? {8'd7, 8'd6} : order == 15 ? {8'd15, 8'd14} : order == 31 ? {8'd31, 8'd28} : 16'd0;
  endfunction
endpackage

// File: rtl/prbs_ref_lfsr.sv
// prbs_ref_lfsr: reference PRBS LFSR, either loaded from received bits or free-running on its own prediction
module prbs_ref_lfsr import serdes_pkg::*; #(
  parameter int ORDER = DEF_PRBS_ORDER
) (
  input  logic clk,
  input  logic reset,
  input  logic adv_i,
  input  logic load_i,
  input  logic din_i,
  output logic pred_o
);
  localparam logic [15:0] TAPS = prbs_taps(ORDER);
  localparam int T_HI = int'(TAPS[15:8]);
  localparam int T_LO = int'(TAPS[7:0]);
  if (TAPS == 16'd0) begin : g_bad_order
    $error("prbs_ref_lfsr: unsupported PRBS order %0d", ORDER);
  end
  logic [ORDER-1:0] lfsr_q, lfsr_d;
  assign pred_o = lfsr_q[T_HI-1] ^ lfsr_q[T_LO-1];
  // shift in either the received bit (self-sync) or the predicted bit (free-run)
  always_comb lfsr_d = adv_i ? {lfsr_q[ORDER-2:0], load_i ? din_i : pred_o} : lfsr_q;
  // state register, all-ones after reset so the predictor is never stuck at zero
  always_ff @(posedge clk)
    if (reset) lfsr_q <= '1;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/serdes_ber_checker.sv
// serdes_ber_checker: PRBS lock FSM with saturating bit/error counters; SERDES_BER_ERR_LOG_EN adds first_err_idx
module serdes_ber_checker import serdes_pkg::*; #(
  parameter int PRBS_ORDER = DEF_PRBS_ORDER,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_WIN = DEF_LOSS_WIN,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic [CNT_W-1:0] window_len,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             meas_done
`ifdef SERDES_BER_ERR_LOG_EN
  ,
  output logic [CNT_W-1:0] first_err_idx
`endif
);
  localparam int SEQ_MAX = PRBS_ORDER > LOCK_CNT ? PRBS_ORDER : LOCK_CNT;
  localparam int SW = $clog2(SEQ_MAX + 1);
  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 2);
  ber_state_e state_q, state_d;
  logic [SW-1:0] seq_q, seq_d;
  logic [WW-1:0] win_bits_q, win_bits_d;
  logic [EW-1:0] win_errs_q, win_errs_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d, bits_inc, errs_inc;
  logic pulse_q, pulse_d, beat, pred, mism;
  assign beat = en & ~clear & data_in_valid;
  assign mism = data_in ^ pred;
  assign bits_inc = &bit_cnt_q ? bit_cnt_q : bit_cnt_q + 1'b1;
  assign errs_inc = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
  prbs_ref_lfsr #(.ORDER(PRBS_ORDER)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .adv_i(beat && state_q inside {SEED, VERIFY, LOCKED}),
    .load_i(state_q != LOCKED),
    .din_i(data_in),
    .pred_o(pred)
  );
  // next state and counters: clear beats en-low beats IDLE start beats data beats
  always_comb begin
    state_d = state_q;
    seq_d = seq_q + 1'b1;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = en ? SEED : IDLE;
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (!en) state_d = IDLE;
    else if (state_q == IDLE) state_d = SEED;
    else if (data_in_valid) begin
      case (state_q)
        SEED: state_d = seq_q == SW'(PRBS_ORDER - 1) ? VERIFY : SEED;
        VERIFY: state_d = mism ? SEED : seq_q == SW'(LOCK_CNT - 1) ? LOCKED : VERIFY;
        LOCKED: begin
          bit_cnt_d = bits_inc;
          err_cnt_d = mism ? errs_inc : err_cnt_q;
          pulse_d = mism;
          win_bits_d = win_bits_q + 1'b1;
          win_errs_d = win_errs_q + EW'(mism);
          if (window_len != '0 && bits_inc >= window_len) state_d = DONE;
          else if (win_errs_d > EW'(LOSS_THRESH)) state_d = SEED;
          else if (win_bits_d == WW'(LOSS_WIN)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end
        end
        default: ;
      endcase
    end else seq_d = seq_q;
    if (clear || state_d != state_q) seq_d = '0;
    if (state_d != LOCKED) begin
      win_bits_d = '0;
      win_errs_d = '0;
    end
  end
  // state and counter registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      seq_q <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      pulse_q <= pulse_d;
    end
  assign locked = state_q == LOCKED;
  assign meas_done = state_q == DONE;
  assign err_pulse = pulse_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;
`ifdef SERDES_BER_ERR_LOG_EN
  logic fe_seen_q, fe_seen_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  // latch the post-increment bit index of the first counted error
  always_comb begin
    fe_seen_d = clear ? 1'b0 : fe_seen_q | pulse_d;
    fe_idx_d = clear ? '0 : pulse_d && !fe_seen_q ? bits_inc : fe_idx_q;
  end
  // first-error log registers
  always_ff @(posedge clk)
    if (reset) begin
      fe_seen_q <= 1'b0;
      fe_idx_q <= '0;
    end else begin
      fe_seen_q <= fe_seen_d;
      fe_idx_q <= fe_idx_d;
    end
  assign first_err_idx = fe_idx_q;
`endif
endmodule
